// File: rtl/jtbubl_sndcomm.sv
// Main-to-sound CPU mailbox: command latch (or 4-deep FIFO when JTBUBL_SNDFIFO_EN
// is defined), reply latch, edge-triggered NMI sequencing and sound-side reset sync.
module jtbubl_sndcomm (
  input  logic       clk24,
  input  logic       rst_n,
  input  logic [7:0] snd_latch,
  input  logic       snd_stb,
  input  logic       snd_rstn,
  output logic [7:0] main_latch,
  output logic       main_stb,
  output logic       snd_flag,
  input  logic       cen,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       nmi_n,
  output logic       snd_cpu_rst_n
);

  typedef enum logic [1:0] {NMI_IDLE, NMI_ARMED, NMI_SERVED} nmi_state_t;

  logic [1:0] rsync_q, rsync_d;
  logic       rd_last_q, rd_last_d;
  logic       wr_last_q, wr_last_d;
  logic [7:0] main_latch_q, main_latch_d;
  logic       main_stb_q, main_stb_d;
  logic [7:0] dout_q, dout_d;
  logic       nmi_en_q, nmi_en_d;
  logic       ovf_q, ovf_d;
  logic [1:0] gap_q, gap_d;
  nmi_state_t state_q, state_d;

  logic       rd_act, wr_act, rd_edge, wr_edge;
  logic       srst, pop, pend, more, ovf_set;
  logic [7:0] head;

  assign srst    = ~rsync_q[1];
  assign rd_act  = cs & ~rd_n;
  assign wr_act  = cs & ~wr_n;
  // Strobe history only advances on cen so a held strobe is seen as one access
  assign rd_edge = cen & rd_act & ~rd_last_q;
  assign wr_edge = cen & wr_act & ~wr_last_q;
  assign pop     = rd_edge & (addr == 2'd0) & pend;

`ifdef JTBUBL_SNDFIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] last_q, last_d;
  logic       push_ok;

  assign pend = (cnt_q != 3'd0);
  assign head = pend ? mem_q[rptr_q] : last_q;

  always_comb begin
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    push_ok = snd_stb & ((cnt_q != 3'd4) | pop);
    ovf_set = snd_stb & ~push_ok;
    wptr_d  = push_ok ? wptr_q + 2'd1 : wptr_q;
    rptr_d  = pop ? rptr_q + 2'd1 : rptr_q;
    last_d  = pop ? mem_q[rptr_q] : last_q;
    cnt_d   = cnt_q + {2'b00, push_ok} - {2'b00, pop};
    more    = (cnt_d != 3'd0);
  end

  always_ff @(posedge clk24) begin
    if (push_ok) mem_q[wptr_q] <= snd_latch;
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      cnt_q  <= 3'd0;
      last_q <= 8'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end
`else
  logic [7:0] cmd_q, cmd_d;
  logic       pend_q, pend_d;

  assign pend = pend_q;
  assign head = cmd_q;

  always_comb begin
    cmd_d   = snd_stb ? snd_latch : cmd_q;
    pend_d  = snd_stb | (pend_q & ~pop);
    // Overwriting an unread command loses it, unless it is being read right now
    ovf_set = snd_stb & pend_q & ~pop;
    more    = pend_d;
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= 8'd0;
      pend_q <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      pend_q <= pend_d;
    end
  end
`endif

  always_comb begin
    rsync_d      = {rsync_q[0], snd_rstn};
    rd_last_d    = cen ? rd_act : rd_last_q;
    wr_last_d    = cen ? wr_act : wr_last_q;
    main_latch_d = main_latch_q;
    main_stb_d   = 1'b0;
    nmi_en_d     = nmi_en_q;
    ovf_d        = ovf_q;
    dout_d       = dout_q;
    if (wr_edge) begin
      case (addr)
        2'd0: begin
          main_latch_d = din;
          main_stb_d   = 1'b1;
        end
        2'd1:    nmi_en_d = 1'b0;
        2'd2:    nmi_en_d = 1'b1;
        default: nmi_en_d = nmi_en_q;
      endcase
    end
    if (srst) nmi_en_d = 1'b0;
    if (rd_edge) begin
      case (addr)
        2'd0:    dout_d = head;
        2'd1:    dout_d = {5'b00000, ovf_q, nmi_en_q, pend};
        default: dout_d = 8'hFF;
      endcase
    end
    if (rd_edge && addr == 2'd1) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      NMI_IDLE: begin
        if (pend && nmi_en_q) state_d = NMI_ARMED;
      end
      NMI_ARMED: begin
        if (pop) begin
          state_d = more ? NMI_SERVED : NMI_IDLE;
          gap_d   = 2'd0;
        end
      end
      NMI_SERVED: begin
        // Hold nmi_n high for two cen cycles so the next command makes a fresh edge
        if (!pend) begin
          state_d = NMI_IDLE;
        end else if (cen) begin
          if (gap_q == 2'd1) begin
            state_d = NMI_ARMED;
            gap_d   = 2'd0;
          end else begin
            gap_d = gap_q + 2'd1;
          end
        end
      end
      default: state_d = NMI_IDLE;
    endcase
    if (srst || (wr_edge && addr == 2'd1)) begin
      state_d = NMI_IDLE;
      gap_d   = 2'd0;
    end
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      rsync_q      <= 2'b00;
      rd_last_q    <= 1'b0;
      wr_last_q    <= 1'b0;
      main_latch_q <= 8'd0;
      main_stb_q   <= 1'b0;
      dout_q       <= 8'hFF;
      nmi_en_q     <= 1'b0;
      ovf_q        <= 1'b0;
      gap_q        <= 2'd0;
      state_q      <= NMI_IDLE;
    end else begin
      rsync_q      <= rsync_d;
      rd_last_q    <= rd_last_d;
      wr_last_q    <= wr_last_d;
      main_latch_q <= main_latch_d;
      main_stb_q   <= main_stb_d;
      dout_q       <= dout_d;
      nmi_en_q     <= nmi_en_d;
      ovf_q        <= ovf_d;
      gap_q        <= gap_d;
      state_q      <= state_d;
    end
  end

  assign main_latch    = main_latch_q;
  assign main_stb      = main_stb_q;
  assign snd_flag      = pend;
  assign dout          = dout_q;
  assign nmi_n         = (state_q != NMI_ARMED);
  assign snd_cpu_rst_n = rst_n & rsync_q[1];

endmodule
